// File: rtl/rob_multi_commit.sv
// Reorder buffer with in-order allocation, multi-port out-of-order writeback
// and in-order multi-slot commit. Halts on the first excepting head entry.
module rob_multi_commit #(
    parameter int ROB_ADDR_SIZE     = 4,
    parameter int DEST_ADDR_SIZE    = 6,
    parameter int INS_TYPE_SIZE     = 2,
    parameter int EXCEPTION_ID_SIZE = 4,
    parameter int DATA_WIDTH        = 32,
    parameter int NUM_WB            = 2,
    parameter int COMMIT_WIDTH      = 2
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  alloc_en,
    input  logic [DEST_ADDR_SIZE-1:0]             alloc_dest_addr,
    input  logic [INS_TYPE_SIZE-1:0]              alloc_ins_type,
    input  logic [EXCEPTION_ID_SIZE-1:0]          alloc_exception,
    output logic [ROB_ADDR_SIZE-1:0]              alloc_id,
    output logic                                  full,
    output logic [ROB_ADDR_SIZE:0]                count,
    input  logic [NUM_WB-1:0]                     wb_valid,
    input  logic [NUM_WB*ROB_ADDR_SIZE-1:0]       wb_rob_id,
    input  logic [NUM_WB*DATA_WIDTH-1:0]          wb_data,
    input  logic [NUM_WB*EXCEPTION_ID_SIZE-1:0]   wb_exception,
    output logic [COMMIT_WIDTH-1:0]               commit_valid,
    output logic [COMMIT_WIDTH*DEST_ADDR_SIZE-1:0] commit_dest_addr,
    output logic [COMMIT_WIDTH*INS_TYPE_SIZE-1:0] commit_ins_type,
    output logic [COMMIT_WIDTH*DATA_WIDTH-1:0]    commit_data,
    output logic                                  halt,
    output logic [EXCEPTION_ID_SIZE-1:0]          exception_id,
    output logic [ROB_ADDR_SIZE-1:0]              exception_rob_id
);

    localparam int DEPTH = 2 ** ROB_ADDR_SIZE;
    localparam logic [ROB_ADDR_SIZE:0] COUNT_ONE = 1;

    logic [DEPTH-1:0]             ent_valid;
    logic [DEPTH-1:0]             ent_finished;
    logic [EXCEPTION_ID_SIZE-1:0] ent_exception [DEPTH];
    logic [DEST_ADDR_SIZE-1:0]    ent_dest      [DEPTH];
    logic [INS_TYPE_SIZE-1:0]     ent_type      [DEPTH];
    logic [DATA_WIDTH-1:0]        ent_data      [DEPTH];

    logic [ROB_ADDR_SIZE-1:0]     head;
    logic [ROB_ADDR_SIZE-1:0]     tail;
    logic [ROB_ADDR_SIZE:0]       num_commit;
    logic                         scan_active;
    logic [ROB_ADDR_SIZE-1:0]     scan_idx;
    logic [NUM_WB-1:0]            wb_accept;
    logic                         alloc_fire;
    logic                         head_excepting;

    // Full and the allocation decision look only at the registered count,
    // so a same-cycle commit never frees a slot early.
    assign full       = (count == (ROB_ADDR_SIZE+1)'(DEPTH));
    assign alloc_id   = tail;
    assign alloc_fire = alloc_en & ~full & ~halt;

    assign head_excepting = ~halt & ent_valid[head] & ent_finished[head]
                          & (ent_exception[head] != '0);

    // Walk from the head and retire the unbroken run of clean finished entries.
    always_comb begin
        commit_valid     = '0;
        commit_dest_addr = '0;
        commit_ins_type  = '0;
        commit_data      = '0;
        num_commit       = '0;
        scan_active      = ~halt;
        scan_idx         = head;
        for (int k = 0; k < COMMIT_WIDTH; k++) begin
            scan_idx = head + ROB_ADDR_SIZE'(k);
            commit_dest_addr[k*DEST_ADDR_SIZE +: DEST_ADDR_SIZE] = ent_dest[scan_idx];
            commit_ins_type[k*INS_TYPE_SIZE +: INS_TYPE_SIZE]    = ent_type[scan_idx];
            commit_data[k*DATA_WIDTH +: DATA_WIDTH]              = ent_data[scan_idx];
            if (scan_active && ent_valid[scan_idx] && ent_finished[scan_idx]
                && (ent_exception[scan_idx] == '0)) begin
                commit_valid[k] = 1'b1;
                num_commit      = num_commit + COUNT_ONE;
            end else begin
                scan_active = 1'b0;
            end
        end
    end

    // A writeback is only accepted into a live entry that has not completed yet.
    always_comb begin
        wb_accept = '0;
        for (int p = 0; p < NUM_WB; p++) begin
            wb_accept[p] = wb_valid[p]
                & ent_valid[wb_rob_id[p*ROB_ADDR_SIZE +: ROB_ADDR_SIZE]]
                & ~ent_finished[wb_rob_id[p*ROB_ADDR_SIZE +: ROB_ADDR_SIZE]];
        end
    end

    // Control state: occupancy bits, pointers, count and the sticky halt.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ent_valid        <= '0;
            ent_finished     <= '0;
            head             <= '0;
            tail             <= '0;
            count            <= '0;
            halt             <= 1'b0;
            exception_id     <= '0;
            exception_rob_id <= '0;
        end else begin
            for (int k = 0; k < COMMIT_WIDTH; k++) begin
                if (commit_valid[k]) begin
                    ent_valid[head + ROB_ADDR_SIZE'(k)] <= 1'b0;
                end
            end
            for (int p = 0; p < NUM_WB; p++) begin
                if (wb_accept[p]) begin
                    ent_finished[wb_rob_id[p*ROB_ADDR_SIZE +: ROB_ADDR_SIZE]] <= 1'b1;
                end
            end
            if (alloc_fire) begin
                ent_valid[tail]    <= 1'b1;
                ent_finished[tail] <= (alloc_exception != '0);
            end
            head  <= head + num_commit[ROB_ADDR_SIZE-1:0];
            tail  <= tail + ROB_ADDR_SIZE'(alloc_fire);
            count <= count + (ROB_ADDR_SIZE+1)'(alloc_fire) - num_commit;
            if (head_excepting) begin
                halt             <= 1'b1;
                exception_id     <= ent_exception[head];
                exception_rob_id <= head;
            end
        end
    end

    // Payload storage; higher-index writeback ports are applied last and win.
    always_ff @(posedge clk) begin
        for (int p = 0; p < NUM_WB; p++) begin
            if (wb_accept[p]) begin
                ent_data[wb_rob_id[p*ROB_ADDR_SIZE +: ROB_ADDR_SIZE]] <=
                    wb_data[p*DATA_WIDTH +: DATA_WIDTH];
                ent_exception[wb_rob_id[p*ROB_ADDR_SIZE +: ROB_ADDR_SIZE]] <=
                    wb_exception[p*EXCEPTION_ID_SIZE +: EXCEPTION_ID_SIZE];
            end
        end
        if (alloc_fire) begin
            ent_dest[tail]      <= alloc_dest_addr;
            ent_type[tail]      <= alloc_ins_type;
            ent_exception[tail] <= alloc_exception;
            ent_data[tail]      <= '0;
        end
    end

endmodule

// File: tb/tb_rob_multi_commit.sv
// Self-checking bench for rob_multi_commit: an in-order queue model of the
// buffer plus directed scenarios with hand-computed expectations.
module tb_rob_multi_commit;

    logic        clk;
    logic        reset;
    logic        alloc_en;
    logic [5:0]  alloc_dest_addr;
    logic [1:0]  alloc_ins_type;
    logic [3:0]  alloc_exception;
    logic [3:0]  alloc_id;
    logic        full;
    logic [4:0]  count;
    logic [1:0]  wb_valid;
    logic [7:0]  wb_rob_id;
    logic [63:0] wb_data;
    logic [7:0]  wb_exception;
    logic [1:0]  commit_valid;
    logic [11:0] commit_dest_addr;
    logic [3:0]  commit_ins_type;
    logic [63:0] commit_data;
    logic        halt;
    logic [3:0]  exception_id;
    logic [3:0]  exception_rob_id;

    int pass_cnt;
    int total_cnt;
    bit cmp_en;
    int dest_ctr;

    rob_multi_commit dut (
        .clk              (clk),
        .reset            (reset),
        .alloc_en         (alloc_en),
        .alloc_dest_addr  (alloc_dest_addr),
        .alloc_ins_type   (alloc_ins_type),
        .alloc_exception  (alloc_exception),
        .alloc_id         (alloc_id),
        .full             (full),
        .count            (count),
        .wb_valid         (wb_valid),
        .wb_rob_id        (wb_rob_id),
        .wb_data          (wb_data),
        .wb_exception     (wb_exception),
        .commit_valid     (commit_valid),
        .commit_dest_addr (commit_dest_addr),
        .commit_ins_type  (commit_ins_type),
        .commit_data      (commit_data),
        .halt             (halt),
        .exception_id     (exception_id),
        .exception_rob_id (exception_rob_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: ordered list of outstanding ids plus per-id payload.
    int         q[$];
    bit         m_fin  [16];
    logic [3:0] m_exc  [16];
    logic [5:0] m_dest [16];
    logic [1:0] m_type [16];
    logic [31:0] m_data[16];
    int         m_tail;
    bit         m_halt;
    logic [3:0] m_eid;
    logic [3:0] m_erid;

    function automatic bit inQueue(input int id);
        foreach (q[i]) if (q[i] == id) return 1'b1;
        return 1'b0;
    endfunction

    // Number of oldest entries that retire given the current model state.
    function automatic int modelCommits();
        int n = 0;
        if (m_halt) return 0;
        for (int k = 0; k < 2 && k < q.size(); k++) begin
            if (m_fin[q[k]] && m_exc[q[k]] == 4'd0) n++;
            else break;
        end
        return n;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        total_cnt++;
        if (actual === expected) pass_cnt++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t",
                      name, actual, expected, $time);
    endtask

    // Model state advances on each clock edge from the pre-edge state.
    always @(posedge clk or posedge reset) begin : model_update
        int nc;
        bit fire;
        bit hx;
        bit ok[2];
        int wid[2];
        if (reset) begin
            q.delete();
            for (int i = 0; i < 16; i++) m_fin[i] = 1'b0;
            m_tail = 0;
            m_halt = 1'b0;
            m_eid  = 4'd0;
            m_erid = 4'd0;
        end else begin
            nc   = modelCommits();
            hx   = !m_halt && q.size() > 0 && m_fin[q[0]] && m_exc[q[0]] != 4'd0;
            fire = alloc_en && q.size() < 16 && !m_halt;
            for (int p = 0; p < 2; p++) begin
                wid[p] = int'(wb_rob_id[p*4 +: 4]);
                ok[p]  = wb_valid[p] && inQueue(wid[p]) && !m_fin[wid[p]];
            end
            for (int p = 0; p < 2; p++) begin
                if (ok[p]) begin
                    m_fin[wid[p]]  = 1'b1;
                    m_data[wid[p]] = wb_data[p*32 +: 32];
                    m_exc[wid[p]]  = wb_exception[p*4 +: 4];
                end
            end
            if (hx) begin
                m_eid  = m_exc[q[0]];
                m_erid = 4'(q[0]);
                m_halt = 1'b1;
            end
            for (int k = 0; k < nc; k++) void'(q.pop_front());
            if (fire) begin
                q.push_back(m_tail);
                m_fin[m_tail]  = (alloc_exception != 4'd0);
                m_exc[m_tail]  = alloc_exception;
                m_dest[m_tail] = alloc_dest_addr;
                m_type[m_tail] = alloc_ins_type;
                m_tail = (m_tail + 1) % 16;
            end
        end
    end

    // Compare every DUT output against the model mid-cycle.
    always @(negedge clk) begin : compare
        int n;
        if (!reset && cmp_en) begin
            n = modelCommits();
            checkOutput("commit_valid", 64'(commit_valid), 64'((1 << n) - 1));
            for (int k = 0; k < n; k++) begin
                checkOutput("commit_data", 64'(commit_data[k*32 +: 32]), 64'(m_data[q[k]]));
                checkOutput("commit_dest", 64'(commit_dest_addr[k*6 +: 6]), 64'(m_dest[q[k]]));
                checkOutput("commit_type", 64'(commit_ins_type[k*2 +: 2]), 64'(m_type[q[k]]));
            end
            checkOutput("count", 64'(count), 64'(q.size()));
            checkOutput("full", 64'(full), 64'(q.size() == 16));
            checkOutput("alloc_id", 64'(alloc_id), 64'(m_tail));
            checkOutput("halt", 64'(halt), 64'(m_halt));
            checkOutput("exception_id", 64'(exception_id), 64'(m_eid));
            checkOutput("exception_rob_id", 64'(exception_rob_id), 64'(m_erid));
        end
    end

    // Drive one cycle of inputs and advance past the next rising edge.
    task automatic applyStimulus(input bit a, input logic [3:0] aexc,
                                 input logic [1:0] wv,
                                 input int id0, input logic [31:0] d0, input logic [3:0] e0,
                                 input int id1, input logic [31:0] d1, input logic [3:0] e1);
        alloc_en        = a;
        alloc_exception = aexc;
        alloc_dest_addr = 6'(dest_ctr);
        alloc_ins_type  = 2'(dest_ctr);
        dest_ctr++;
        wb_valid        = wv;
        wb_rob_id       = {4'(id1), 4'(id0)};
        wb_data         = {d1, d0};
        wb_exception    = {e1, e0};
        @(posedge clk);
        #1;
    endtask

    task automatic allocN(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1, 0, 2'b00, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic idle();
        applyStimulus(0, 0, 2'b00, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic doReset();
        #2 reset = 1'b1;
        #2 reset = 1'b0;
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        cmp_en    = 1'b0;
        dest_ctr  = 1;
        reset     = 1'b1;
        alloc_en  = 1'b0;
        alloc_dest_addr = '0;
        alloc_ins_type  = '0;
        alloc_exception = '0;
        wb_valid  = '0;
        wb_rob_id = '0;
        wb_data   = '0;
        wb_exception = '0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_count", 64'(count), 64'd0);
        checkOutput("reset_halt", 64'(halt), 64'd0);
        reset  = 1'b0;
        cmp_en = 1'b1;

        // Asynchronous reset in the middle of a cycle after five allocations.
        allocN(5);
        checkOutput("pre_reset_count", 64'(count), 64'd5);
        #2 reset = 1'b1;
        #1;
        checkOutput("async_count", 64'(count), 64'd0);
        checkOutput("async_full", 64'(full), 64'd0);
        checkOutput("async_halt", 64'(halt), 64'd0);
        checkOutput("async_commit_valid", 64'(commit_valid), 64'd0);
        checkOutput("async_alloc_id", 64'(alloc_id), 64'd0);
        #1 reset = 1'b0;

        // Out-of-order completion; retirement waits for the oldest entry.
        allocN(3);
        applyStimulus(0, 0, 2'b01, 2, 32'hA, 0, 0, 0, 0);
        checkOutput("ooo_wait1", 64'(commit_valid), 64'd0);
        applyStimulus(0, 0, 2'b01, 1, 32'hB, 0, 0, 0, 0);
        checkOutput("ooo_wait2", 64'(commit_valid), 64'd0);
        applyStimulus(0, 0, 2'b01, 0, 32'hC, 0, 0, 0, 0);
        checkOutput("ooo_cv_pair", 64'(commit_valid), 64'd3);
        checkOutput("ooo_slot0", 64'(commit_data[31:0]), 64'hC);
        checkOutput("ooo_slot1", 64'(commit_data[63:32]), 64'hB);
        idle();
        checkOutput("ooo_cv_last", 64'(commit_valid), 64'd1);
        checkOutput("ooo_slot0_last", 64'(commit_data[31:0]), 64'hA);
        idle();
        checkOutput("ooo_empty", 64'(count), 64'd0);

        // Fill, overflow attempt, commit-vs-alloc at full, then wrapped drain.
        doReset();
        allocN(16);
        checkOutput("fill_full", 64'(full), 64'd1);
        checkOutput("fill_alloc_id", 64'(alloc_id), 64'd0);
        allocN(1);
        checkOutput("fill_drop", 64'(count), 64'd16);
        applyStimulus(1, 0, 2'b01, 0, 32'h50, 0, 0, 0, 0);
        checkOutput("fill_cv", 64'(commit_valid), 64'd1);
        checkOutput("fill_still_full", 64'(count), 64'd16);
        allocN(1);
        checkOutput("fill_after_commit", 64'(count), 64'd15);
        checkOutput("fill_wrap_id", 64'(alloc_id), 64'd0);
        allocN(1);
        checkOutput("fill_refill", 64'(count), 64'd16);
        checkOutput("fill_next_id", 64'(alloc_id), 64'd1);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(0, 0, 2'b11, 2*i + 1, 32'h100 + 32'(2*i + 1), 0,
                          (2*i + 2) % 16, 32'h100 + 32'((2*i + 2) % 16), 0);
        end
        begin : drain
            int budget = 20;
            while (count != 5'd0 && budget > 0) begin
                idle();
                budget--;
            end
            checkOutput("drain_done", 64'(count), 64'd0);
        end

        // Exception in the middle of a run stops commit and raises halt.
        doReset();
        allocN(4);
        applyStimulus(0, 0, 2'b11, 0, 32'h20, 0, 1, 32'h21, 0);
        checkOutput("exc_pair", 64'(commit_valid), 64'd3);
        applyStimulus(0, 0, 2'b11, 2, 32'h22, 4'h5, 3, 32'h23, 0);
        checkOutput("exc_stop", 64'(commit_valid), 64'd0);
        checkOutput("exc_not_yet", 64'(halt), 64'd0);
        idle();
        checkOutput("exc_halt", 64'(halt), 64'd1);
        checkOutput("exc_id", 64'(exception_id), 64'd5);
        checkOutput("exc_rob_id", 64'(exception_rob_id), 64'd2);
        allocN(3);
        checkOutput("exc_frozen", 64'(count), 64'd2);

        // Two ports hitting the same entry: the higher port's data is kept.
        doReset();
        allocN(5);
        applyStimulus(0, 0, 2'b11, 4, 32'h11, 0, 4, 32'h22, 0);
        applyStimulus(0, 0, 2'b11, 0, 32'h30, 0, 1, 32'h31, 0);
        applyStimulus(0, 0, 2'b11, 2, 32'h32, 0, 3, 32'h33, 0);
        idle();
        checkOutput("dup_cv", 64'(commit_valid), 64'd1);
        checkOutput("dup_data", 64'(commit_data[31:0]), 64'h22);
        idle();

        // Decode-time exception at the head halts two edges after allocation.
        doReset();
        applyStimulus(1, 4'h3, 2'b00, 0, 0, 0, 0, 0, 0);
        checkOutput("dec_no_commit", 64'(commit_valid), 64'd0);
        checkOutput("dec_not_yet", 64'(halt), 64'd0);
        idle();
        checkOutput("dec_halt", 64'(halt), 64'd1);
        checkOutput("dec_rob_id", 64'(exception_rob_id), 64'd0);
        checkOutput("dec_id", 64'(exception_id), 64'd3);
        idle();

        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/rob_multi_commit.md
Name: rob_multi_commit

Overview:
- Parametrised reorder buffer for the writeback/commit stage.
- Accepts one in-order allocation per cycle from ID and NUM_WB out-of-order completions per cycle from EX.
- Retires up to COMMIT_WIDTH oldest finished entries per cycle, in order, with their result data.
- On the first excepting head it stops retirement, raises a sticky halt, and records the exception cause and ROB id.

Parameters:
ROB_ADDR_SIZE, 4, log2 of entry count (DEPTH = 2**ROB_ADDR_SIZE)
DEST_ADDR_SIZE, 6, destination address width
INS_TYPE_SIZE, 2, instruction type width (00 none, 01 store, 10 reg, 11 pred)
EXCEPTION_ID_SIZE, 4, exception code width (0 = no exception)
DATA_WIDTH, 32, result data width
NUM_WB, 2, writeback ports
COMMIT_WIDTH, 2, maximum retirements per cycle (1..DEPTH)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
alloc_en  in  1  allocate an entry at the tail
alloc_dest_addr  in  DEST_ADDR_SIZE  destination of the allocated entry
alloc_ins_type  in  INS_TYPE_SIZE  type of the allocated entry
alloc_exception  in  EXCEPTION_ID_SIZE  decode-time exception; nonzero marks the entry finished and excepting
alloc_id  out  ROB_ADDR_SIZE  tail id handed to ID
full  out  1  no free entry (registered count == DEPTH)
count  out  ROB_ADDR_SIZE+1  occupied entries
wb_valid  in  NUM_WB  per-port completion strobe
wb_rob_id  in  NUM_WB*ROB_ADDR_SIZE  packed completion ids, port 0 in the LSBs
wb_data  in  NUM_WB*DATA_WIDTH  packed results
wb_exception  in  NUM_WB*EXCEPTION_ID_SIZE  packed exception codes
commit_valid  out  COMMIT_WIDTH  slot k retires this cycle; thermometer code from bit 0
commit_dest_addr  out  COMMIT_WIDTH*DEST_ADDR_SIZE  slot k = entry head+k
commit_ins_type  out  COMMIT_WIDTH*INS_TYPE_SIZE  per slot
commit_data  out  COMMIT_WIDTH*DATA_WIDTH  per slot
halt  out  1  sticky exception halt
exception_id  out  EXCEPTION_ID_SIZE  cause latched at halt
exception_rob_id  out  ROB_ADDR_SIZE  entry id latched at halt

Behaviour:
- Reset (asynchronous, any time, including mid-operation):
  - head, tail and count go to 0; all entry valid/finished bits clear.
  - halt, exception_id and exception_rob_id go to 0; commit_valid goes to 0.
  - full=0, alloc_id=0.
- Entry state: valid, finished, exception, dest, type, data.
- Allocation:
  - Takes effect at the clock edge when alloc_en & ~full & ~halt; otherwise alloc_en is ignored.
  - full uses the registered count only. A commit in the same cycle does not free a slot until the next cycle.
  - Tail wraps modulo DEPTH.
- Writeback:
  - At the edge, each port with wb_valid whose id is a valid, unfinished entry sets finished and writes data and exception.
  - Writebacks to invalid or already-finished entries are ignored.
  - Same id on two ports in one cycle: the highest-index port wins.
  - There is no same-cycle bypass into commit. An entry written back at edge N can first appear on commit_valid in the cycle after edge N.
- Commit (combinational from registered state):
  - commit_valid[k] = ~halt & for all j<=k: entry (head+j) is valid, finished, and has exception==0.
  - Scanning stops at the first entry that fails the test; later slots stay low even if their entries are finished.
  - At the edge: head += number of committed slots, count is updated, and committed entries become invalid.
  - count_next = count + alloc_fire - commits.
  - Simultaneous alloc and commit are legal, including when count == DEPTH.
- Exception:
  - If the head entry is valid, finished and its exception is nonzero, then at the next edge: halt<=1, exception_id<=code, exception_rob_id<=head.
  - Entries older than the excepting head commit normally in earlier cycles, never in the same cycle, because the scan stops at the exception.
  - Once halted: no alloc, no commit, writebacks still update state. halt clears only on reset.
- Empty (count==0): commit_valid=0.
- Full: alloc_id still shows the tail; the allocation is dropped.
- DEPTH wrap: ids compare modulo DEPTH; commit slots wrap past the last entry to entry 0.

Test Plan:
- Reset mid-stream after 5 allocs -> count=0, full=0, halt=0, commit_valid=0, alloc_id=0 with no clock edge needed.
- Alloc ids 0,1,2; wb id2 then id1 then id0 one per cycle, data 0xA,0xB,0xC -> no commit until id0 writes back; the next cycle commit_valid=2'b11 with data 0xC,0xB; the following cycle slot0 commits 0xA.
- Fill 16 entries -> full=1 and a 17th alloc is dropped; then wb id0 and hold alloc_en -> the commit cycle drops the alloc; the next cycle the alloc succeeds with alloc_id=0 (wrapped).
- Alloc 0..3; wb all, id2 with exception 0x5 -> commit 0,1 together; next cycle commit_valid=0; following edge halt=1, exception_id=5, exception_rob_id=2; entry 3 never commits.
- Ports 0 and 1 both write id4 with data 0x11 and 0x22 in one cycle -> the committed data is 0x22.
- Alloc with alloc_exception=0x3 at head -> halt=1 two edges after the alloc, exception_rob_id equals that id, and there is no commit.
